// File: rtl/seq_div_if.sv
// Handshake and data bundle between the execute stage and the sequential divider.
interface seq_div_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: issues operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, is_signed, flush, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, is_signed, flush, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div.sv
// Radix-2 restoring divider: one quotient bit per cycle, RISC-V M-extension
// divide-by-zero and signed-overflow results, flushable while in flight.
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  seq_div_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fin;      // iterations exhausted; next CALC cycle finalises
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;      // stored remainder is always < divisor, so WIDTH bits suffice
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_finish;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_quo_sh;

  // Magnitude of a two's-complement operand; untouched for unsigned operation.
  function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return (sgn && v[WIDTH-1]) ? WIDTH'(-s) : v;
  endfunction

  // Final sign correction of a magnitude result.
  function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return neg ? WIDTH'(-s) : v;
  endfunction

  assign w_div_zero = (bus.divisor == '0);
  assign w_ovf      = bus.is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  assign w_accept   = (r_state == S_IDLE) && bus.in_valid && !bus.flush;
  assign w_finish   = (r_state == S_CALC) && r_fin && !bus.flush;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};
  assign w_quo_sh = {r_quo[WIDTH-2:0], 1'b0};

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.in_valid)  w_next = S_CALC;
        S_CALC:  if (r_fin)         w_next = S_DONE;
        S_DONE:  if (bus.out_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Iteration counter; special cases arrive with r_fin already set so they
  // spend a single CALC cycle before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_fin <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= CNT_W'(WIDTH - 1);
      r_fin <= w_div_zero || w_ovf;
    end else if (r_state == S_CALC && !r_fin) begin
      if (r_cnt == '0) r_fin <= 1'b1;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  // Working datapath: operand load on accept, one quotient bit per CALC cycle.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_div <= f_abs(bus.divisor, bus.is_signed);
      if (w_div_zero) begin
        r_quo  <= '1;
        r_rem  <= bus.dividend;
        r_qneg <= 1'b0;
        r_rneg <= 1'b0;
      end else if (w_ovf) begin
        r_quo  <= bus.dividend;
        r_rem  <= '0;
        r_qneg <= 1'b0;
        r_rneg <= 1'b0;
      end else begin
        r_quo  <= f_abs(bus.dividend, bus.is_signed);
        r_rem  <= '0;
        r_qneg <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
        r_rneg <= bus.is_signed && bus.dividend[WIDTH-1];
      end
    end else if (r_state == S_CALC && !r_fin) begin
      if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {w_quo_sh[WIDTH-1:1], 1'b1};
      end else begin
        r_rem <= w_rem_sh[WIDTH-1:0];
        r_quo <= w_quo_sh;
      end
    end
  end

  // Result registers: written only when a result is committed, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_accept) r_dbz <= w_div_zero;
      if (w_finish) begin
        r_quotient  <= f_apply_sign(r_quo, r_qneg);
        r_remainder <= f_apply_sign(r_rem, r_rneg);
      end
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed vector table, randomized ops against an
// arithmetic reference, plus backpressure, flush and async-reset sequences.
module tb_seq_div;
  localparam int W = 32;
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_div_if #(.WIDTH(W)) bus();
  seq_div #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic with RISC-V divide rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dbz, output int lat);
    longint sa, sb;
    dbz = 1'b0;
    lat = W + 1;
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1; lat = 1;
    end else if (sgn && a == MINN && b == '1) begin
      q = a; r = '0; lat = 1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    bus.dividend = a; bus.divisor = b; bus.is_signed = sgn; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output int lat);
    start_op(a, b, sgn);
    wait_valid(lat);
    q = bus.quotient; r = bus.remainder; dbz = bus.div_by_zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q, r, eq, er, a, b;
    logic         dbz, edbz, sgn, seen;
    int           lat, elat;

    tbl[0] = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 33};
    tbl[1] = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    tbl[2] = '{32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        1'b0, 33};
    tbl[3] = '{32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    tbl[4] = '{32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    tbl[5] = '{32'd9,        32'd3,        1'b0, 32'd3,        32'd0,        1'b0, 33};
    tbl[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1};
    tbl[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 33};
    tbl[8] = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    tbl[9] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 33};

    bus.in_valid = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.is_signed = 1'b0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    check("reset in_ready", W'(bus.in_ready), W'(1));
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset quotient", bus.quotient, '0);
    check("reset remainder", bus.remainder, '0);
    check("reset div_by_zero", W'(bus.div_by_zero), W'(0));

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sgn, q, r, dbz, lat);
      check($sformatf("vec%0d quotient", i), q, tbl[i].q);
      check($sformatf("vec%0d remainder", i), r, tbl[i].r);
      check($sformatf("vec%0d div_by_zero", i), W'(dbz), W'(tbl[i].dbz));
      check($sformatf("vec%0d latency", i), W'(lat), W'(tbl[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        3:       begin a = MINN; b = '1; end
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(a, b, sgn, eq, er, edbz, elat);
      run_op(a, b, sgn, q, r, dbz, lat);
      check($sformatf("rand%0d %h/%h s=%0d quotient", i, a, b, sgn), q, eq);
      check($sformatf("rand%0d remainder", i), r, er);
      check($sformatf("rand%0d div_by_zero", i), W'(dbz), W'(edbz));
      check($sformatf("rand%0d latency", i), W'(lat), W'(elat));
    end

    // Backpressure: result held in DONE while out_ready is low.
    start_op(32'd100, 32'd7, 1'b0);
    wait_valid(lat);
    check("bp latency", W'(lat), W'(33));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", i), W'(bus.out_valid), W'(1));
      check($sformatf("bp%0d in_ready", i), W'(bus.in_ready), W'(0));
      check($sformatf("bp%0d quotient", i), bus.quotient, 32'd14);
      check($sformatf("bp%0d remainder", i), bus.remainder, 32'd2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp release out_valid", W'(bus.out_valid), W'(0));
    check("bp release in_ready", W'(bus.in_ready), W'(1));
    check("bp held quotient", bus.quotient, 32'd14);
    run_op(32'd9, 32'd3, 1'b0, q, r, dbz, lat);
    check("bp next quotient", q, 32'd3);
    check("bp next remainder", r, 32'd0);

    // Flush at CALC cycle 10: back to IDLE, no result, outputs untouched.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush in_ready", W'(bus.in_ready), W'(1));
    check("flush out_valid", W'(bus.out_valid), W'(0));
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    check("flush no result", W'(seen), W'(0));
    check("flush quotient held", bus.quotient, 32'd3);

    // Flush coincident with accept discards the operation.
    bus.dividend = 32'd20; bus.divisor = 32'd0; bus.is_signed = 1'b0;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush-accept in_ready", W'(bus.in_ready), W'(1));
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
    check("flush-accept no result", W'(seen), W'(0));
    check("flush-accept div_by_zero", W'(bus.div_by_zero), W'(0));

    // Asynchronous reset at CALC cycle 20 clears outputs between edges.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async rst quotient", bus.quotient, '0);
    check("async rst remainder", bus.remainder, '0);
    check("async rst out_valid", W'(bus.out_valid), W'(0));
    check("async rst in_ready", W'(bus.in_ready), W'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd100, 32'd7, 1'b0, q, r, dbz, lat);
    check("post-rst quotient", q, 32'd14);
    check("post-rst remainder", r, 32'd2);
    check("post-rst latency", W'(lat), W'(33));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
